alu_arbiter: RTL



---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 35 +++
 rtl/rr_arbiter.sv | 63 ++++++
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcode encoding, arbiter FSM states and an opcode legality helper.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_op_e;

  localparam logic [ALU_OP_W-1:0] ALU_OP_LAST = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic op_is_legal(input logic [ALU_OP_W-1:0] op);
    return op <= ALU_OP_LAST;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU for the R/I-type datapath; shifts use the low log2(DATA_WIDTH) bits of b.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [ALU_OP_W-1:0]   op_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int SH_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [SH_W-1:0] shamt;
  assign shamt = b_i[SH_W-1:0];

  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_ADD:  res_o = a_i + b_i;
      ALU_SUB:  res_o = a_i - b_i;
      ALU_SLL:  res_o = a_i << shamt;
      ALU_SLT:  res_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: res_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  res_o = a_i ^ b_i;
      ALU_SRL:  res_o = a_i >> shamt;
      ALU_SRA:  res_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   res_o = a_i | b_i;
      ALU_AND:  res_o = a_i & b_i;
      default:  res_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer and wraps; pointer moves past the winner on update.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic               upd_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_valid_o
);

  localparam int SW = ID_W + 1;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    slot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] hit;
  logic               found;

  // Slot k is requester (ptr + k) mod NUM_REQ, so slot 0 has highest priority.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    logic [SW-1:0] sum;
    assign sum           = {1'b0, ptr_q} + SW'(gi);
    assign slot_idx[gi]  = (sum >= SW'(NUM_REQ)) ? ID_W'(sum - SW'(NUM_REQ)) : sum[ID_W-1:0];
    assign hit[gi]       = req_i[slot_idx[gi]];
  end

  always_comb begin
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && hit[k]) begin
        found     = 1'b1;
        gnt_idx_o = slot_idx[k];
      end
    end
  end

  assign gnt_valid_o = en_i & found;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
    assign gnt_o[gi] = gnt_valid_o && (gnt_idx_o == ID_W'(gi));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = (gnt_idx_o == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: grant, execute for one cycle, hold a tagged response until accepted.
// Define ALU_ARB_OPCHECK_EN to flag illegal opcodes on rsp_err_o and force their result to zero.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*ALU_OP_W-1:0]   req_op_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic                          rsp_err_o
);

  arb_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [ALU_OP_W-1:0]   op_q, op_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;

  logic                  arb_en;
  logic                  gnt_valid;
  logic [ID_W-1:0]       gnt_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic [DATA_WIDTH-1:0] sel_a, sel_b, alu_res;
  logic [ALU_OP_W-1:0]   sel_op;

  // Arbiter opens in IDLE, or in RESP when the result leaves this cycle; held shut during reset.
  assign arb_en = rst_ni && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_valid_i),
    .en_i        (arb_en),
    .upd_i       (gnt_valid),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign req_ready_o = gnt;

  always_comb begin
    sel_a  = req_a_i[DATA_WIDTH-1:0];
    sel_b  = req_b_i[DATA_WIDTH-1:0];
    sel_op = req_op_i[ALU_OP_W-1:0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a  = req_a_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b  = req_b_i[i*DATA_WIDTH +: DATA_WIDTH];
        sel_op = req_op_i[i*ALU_OP_W +: ALU_OP_W];
      end
    end
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (op_q),
    .res_o (alu_res)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = gnt_valid ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response registers only change at the end of EXEC, so they stay put throughout RESP.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    data_d   = data_q;
    rsp_id_d = rsp_id_q;
    if (gnt_valid) begin
      a_d  = sel_a;
      b_d  = sel_b;
      op_d = sel_op;
      id_d = gnt_idx;
    end
    if (state_q == EXEC) begin
      data_d   = alu_res;
      rsp_id_d = id_q;
`ifdef ALU_ARB_OPCHECK_EN
      if (!op_is_legal(op_q)) data_d = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= '0;
      data_q   <= '0;
      rsp_id_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      data_q   <= data_d;
      rsp_id_q <= rsp_id_d;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == EXEC) err_d = !op_is_legal(op_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = data_q;
  assign rsp_id_o    = rsp_id_q;

endmodule
